// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command handshake and open-drain line signals of the PS/2 host transmitter
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  modport master (
    output tx_data, tx_start, ps2_clk_in, ps2_data_in,
    input  tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe
  );

  modport slave (
    input  tx_data, tx_start, ps2_clk_in, ps2_data_in,
    output tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter with open-drain enables
// Define PS2_TX_RETRY_EN to retry a failed frame once before reporting tx_error.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 1200,
  parameter int TIMEOUT_CYCLES = 150000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic         clock,
  input  logic         reset,
  ps2_host_tx_if.slave bus
);
  localparam int CW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_XFER, S_WAIT_IDLE, S_DONE, S_ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [3:0]      bit_q, bit_d;
  logic [8:0]      frame_q, frame_d;
  logic            data_oe_q, data_oe_d;
  logic            fail;
`ifdef PS2_TX_RETRY_EN
  logic            retry_q, retry_d;
`endif

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic            clk_filt_q, data_filt_q, clk_prev_q;
  logic            fall;

  // Filtered levels only move once every synchronizer stage agrees, which drops short glitches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_filt_q  <= 1'b1;
      data_filt_q <= 1'b1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk_in};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus.ps2_data_in};
      if (&clk_sync_q)        clk_filt_q <= 1'b1;
      else if (~|clk_sync_q)  clk_filt_q <= 1'b0;
      if (&data_sync_q)       data_filt_q <= 1'b1;
      else if (~|data_sync_q) data_filt_q <= 1'b0;
      clk_prev_q <= clk_filt_q;
    end
  end

  assign fall = clk_prev_q & ~clk_filt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      data_oe_q <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      data_oe_q <= data_oe_d;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    data_oe_d = data_oe_q;
    fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.tx_start) begin
          frame_d = {~^bus.tx_data, bus.tx_data};
          cnt_d   = '0;
          state_d = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d = 1'b0;
`endif
        end
      end
      S_INHIBIT: begin
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_REQ: begin
        if (cnt_q == CW'(1)) begin
          tmo_d     = '0;
          bit_d     = '0;
          data_oe_d = 1'b1;
          state_d   = S_XFER;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_XFER: begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          fail = 1'b1;
        end else if (fall) begin
          bit_d = bit_q + 4'd1;
          // bit_q holds falls already seen: 0..8 data+parity, 9 stop, 10 is the ACK slot.
          if (bit_q < 4'd9)        data_oe_d = ~frame_q[bit_q];
          else if (bit_q == 4'd9)  data_oe_d = 1'b0;
          else if (data_filt_q)    fail = 1'b1;
          else                     state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) fail = 1'b1;
        else if (clk_filt_q && data_filt_q)   state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (fail) begin
      data_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (!retry_q) begin
        retry_d = 1'b1;
        cnt_d   = '0;
        state_d = S_INHIBIT;
      end else begin
        state_d = S_ERROR;
      end
`else
      state_d = S_ERROR;
`endif
    end
  end

  assign bus.tx_busy     = state_q inside {S_INHIBIT, S_REQ, S_XFER, S_WAIT_IDLE};
  assign bus.tx_done     = (state_q == S_DONE);
  assign bus.tx_error    = (state_q == S_ERROR);
  assign bus.ps2_clk_oe  = state_q inside {S_INHIBIT, S_REQ};
  assign bus.ps2_data_oe = (state_q == S_REQ) || ((state_q == S_XFER) && data_oe_q);
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 keyboard model
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TMO = 2000;
  localparam int HALF = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ps2_host_tx_if bus ();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad = 0;
  longint cyc = 0;

  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  bit   dev_active = 1'b0;
  bit   dev_noclk = 1'b0;
  int   nack_left = 0;
  int   dev_t = 0;
  int   dev_edge = 0;
  logic [9:0] dev_frame;

  logic [9:0] exp_wire[$];
  int         exp_resp[$];

  bit     timeout_chk = 1'b0;
  longint release_cyc = 0;
  int     inh_phases = 0;

  assign bus.ps2_clk_in  = dev_clk & ~bus.ps2_clk_oe;
  assign bus.ps2_data_in = dev_data & ~bus.ps2_data_oe;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame: {stop=1, odd parity, byte}, parity from a plain count of ones.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
  endfunction

  // Keyboard model: clocks 11 periods after a request, samples on rising edges, ACKs at fall 11.
  initial forever begin
    @(negedge clock);
    if (reset) begin
      dev_active = 1'b0;
      dev_clk = 1'b1;
      dev_data = 1'b1;
    end else if (!dev_active) begin
      if (!dev_noclk && bus.ps2_clk_in && !bus.ps2_data_in) begin
        dev_active = 1'b1;
        dev_t = 0;
        dev_edge = 0;
        dev_frame = '0;
      end
    end else begin
      dev_t++;
      if (dev_t % (2 * HALF) == HALF) begin
        dev_clk = 1'b0;
        dev_edge++;
        if (dev_edge == 11) begin
          if (nack_left > 0) begin
            dev_data = 1'b1;
            nack_left--;
          end else begin
            dev_data = 1'b0;
          end
        end
      end else if (dev_t % (2 * HALF) == 0) begin
        dev_clk = 1'b1;
        if (dev_edge <= 10) dev_frame[dev_edge-1] = bus.ps2_data_in;
        if (dev_edge == 11) begin
          dev_active = 1'b0;
          dev_data = 1'b1;
          if (exp_wire.size() == 0) begin
            check("unexpected_frame", dev_frame, 10'h3ff);
          end else begin
            check("wire_frame", dev_frame, exp_wire.pop_front());
          end
        end
      end
    end
  end

  // Response monitor: phase lengths at every clock release, done/error against the queue.
  initial begin : monitor
    int  inh_run = 0;
    int  req_run = 0;
    bit  prev_clk_oe = 1'b0;
    bit  busy_chk = 1'b0;
    int  e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (busy_chk) begin
          check("busy_after_resp", bus.tx_busy, 0);
          busy_chk = 1'b0;
        end
        if (bus.ps2_clk_oe && !bus.ps2_data_oe) inh_run++;
        if (bus.ps2_clk_oe && bus.ps2_data_oe) req_run++;
        if (!bus.ps2_clk_oe && prev_clk_oe) begin
          check("inhibit_len", inh_run, INH);
          check("req_len", req_run, 2);
          release_cyc = cyc;
          inh_phases++;
          inh_run = 0;
          req_run = 0;
        end
        if (bus.tx_done || bus.tx_error) begin
          check("done_and_error", bus.tx_done && bus.tx_error, 0);
          if (exp_resp.size() == 0) begin
            check("unexpected_resp", bus.tx_error, 2);
          end else begin
            e = exp_resp.pop_front();
            check("resp_is_error", bus.tx_error, e);
          end
          if (bus.tx_error) begin
            check("err_clk_oe", bus.ps2_clk_oe, 0);
            check("err_data_oe", bus.ps2_data_oe, 0);
            if (timeout_chk) check("timeout_cycles", cyc - release_cyc, TMO);
          end
          busy_chk = 1'b1;
        end
      end
      prev_clk_oe = bus.ps2_clk_oe;
    end
  end

  task automatic wait_idle();
    int k = 0;
    while ((bus.tx_busy || dev_active) && k < 20000) begin
      @(negedge clock);
      k++;
    end
    if (k >= 20000) begin
      total++;
      bad++;
      $display("FAIL wait_idle: busy=%0d dev_active=%0d after %0d cycles", bus.tx_busy, dev_active, k);
    end
  endtask

  task automatic send(input logic [7:0] b, input int frames, input bit ok, input bit spam);
    int k = 0;
    wait_idle();
    @(negedge clock);
    for (int i = 0; i < frames; i++) exp_wire.push_back(frame_of(b));
    exp_resp.push_back(ok ? 0 : 1);
    bus.tx_data = b;
    bus.tx_start = 1'b1;
    @(negedge clock);
    bus.tx_start = 1'b0;
    bus.tx_data = 8'($urandom);
    while ((exp_resp.size() != 0 || dev_active) && k < 20000) begin
      if (spam && k > 5 && k < 300 && (k % 37) == 0) begin
        bus.tx_start = 1'b1;
        bus.tx_data = 8'h55;
      end else begin
        bus.tx_start = 1'b0;
      end
      @(negedge clock);
      k++;
    end
    bus.tx_start = 1'b0;
    if (k >= 20000) begin
      total++;
      bad++;
      $display("FAIL send_%02h: no response after %0d cycles", b, k);
    end
  endtask

  initial begin
    int p0;
    int k;
    bus.tx_data = 8'h00;
    bus.tx_start = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy", bus.tx_busy, 0);
    check("rst_done", bus.tx_done, 0);
    check("rst_error", bus.tx_error, 0);
    check("rst_clk_oe", bus.ps2_clk_oe, 0);
    check("rst_data_oe", bus.ps2_data_oe, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    send(8'hED, 1, 1'b1, 1'b0);
    send(8'h07, 1, 1'b1, 1'b0);
    send(8'h00, 1, 1'b1, 1'b0);

`ifdef PS2_TX_RETRY_EN
    nack_left = 1;
    p0 = inh_phases;
    send(8'hA5, 2, 1'b1, 1'b0);
    check("retry_phases", inh_phases - p0, 2);
    nack_left = 2;
    send(8'h3C, 2, 1'b0, 1'b0);
`else
    nack_left = 1;
    p0 = inh_phases;
    send(8'hA5, 1, 1'b0, 1'b0);
    check("nack_phases", inh_phases - p0, 1);
`endif
    nack_left = 0;

    dev_noclk = 1'b1;
    timeout_chk = 1'b1;
    send(8'h5A, 0, 1'b0, 1'b0);
    timeout_chk = 1'b0;
    dev_noclk = 1'b0;

    send(8'hF4, 1, 1'b1, 1'b1);

    // Abort mid-frame: reset must release both lines without waiting for a clock edge.
    wait_idle();
    @(negedge clock);
    bus.tx_data = 8'hA5;
    bus.tx_start = 1'b1;
    @(negedge clock);
    bus.tx_start = 1'b0;
    k = 0;
    while (!(dev_active && dev_edge == 5 && !dev_clk) && k < 5000) begin
      @(negedge clock);
      k++;
    end
    repeat (6) @(negedge clock);
    check("pre_rst_data_oe", bus.ps2_data_oe, 1);
    #2 reset = 1'b1;
    #1;
    check("async_clk_oe", bus.ps2_clk_oe, 0);
    check("async_data_oe", bus.ps2_data_oe, 0);
    check("async_busy", bus.tx_busy, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    send(8'hFF, 1, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clock);
      send(8'($urandom), 1, 1'b1, 1'($urandom_range(0, 1)));
    end

    wait_idle();
    repeat (5) @(negedge clock);
    check("wire_queue_left", exp_wire.size(), 0);
    check("resp_queue_left", exp_resp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
